// File: rtl/io_port_hub_pkg.sv
// Shared helpers for the IO port hub: pointer sizing and packed-bus channel slicing.
package io_port_hub_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int chan_lsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the head word.
module io_fifo
  import io_port_hub_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int FDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [NUBITS-1:0]       wdata,
  output logic [NUBITS-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(FDEPTH):0] count
);

  localparam int PW = ptr_width(FDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FDEPTH);

  logic [NUBITS-1:0] mem_q [FDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_port_hub.sv
// Processor IO hub: buffered producer input channels and single-register output channels.
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int                 NUBITS = 16,
  parameter int                 NUIOIN = 2,
  parameter int                 NUIOOU = 2,
  parameter int                 FDEPTH = 4,
  parameter logic [NUIOIN-1:0]  ITRMSK = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [NUBITS-1:0]          io_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  input  logic                       req_in,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   in_data,
  input  logic [NUIOIN-1:0]          in_valid,
  output logic [NUIOIN-1:0]          in_ready,
  output logic [NUIOOU*NUBITS-1:0]   out_data,
  output logic [NUIOOU-1:0]          out_valid,
  input  logic [NUIOOU-1:0]          out_ready,
  output logic                       err_udf,
  output logic                       err_ovr
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam int CW  = $clog2(FDEPTH) + 1;

  logic [NUBITS-1:0] fifo_rdata [NUIOIN];
  logic [CW-1:0]     fifo_count [NUIOIN];
  logic [NUIOIN-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, fill_edge;

  logic [NUBITS-1:0] out_data_q [NUIOOU];
  logic [NUBITS-1:0] out_data_d [NUIOOU];
  logic [NUIOOU-1:0] out_valid_q, out_valid_d;
  logic              itr_q, itr_d;
  logic              err_udf_q, err_udf_d;
  logic              err_ovr_q, err_ovr_d;
  logic              rd_ok, wr_hit, ovr_set;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    // Ready is held low while reset is asserted so no producer word is accepted then.
    assign in_ready[k]  = rst & ~fifo_full[k];
    assign fifo_push[k] = in_valid[k] & in_ready[k];

    io_fifo #(
      .NUBITS (NUBITS),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[k]),
      .pop   (fifo_pop[k]),
      .wdata (in_data[chan_lsb(k, NUBITS) +: NUBITS]),
      .rdata (fifo_rdata[k]),
      .full  (fifo_full[k]),
      .empty (fifo_empty[k]),
      .count (fifo_count[k])
    );
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    assign out_data[chan_lsb(j, NUBITS) +: NUBITS] = out_data_q[j];
  end

  // Read side: a read of an empty or nonexistent channel returns zero and flags underflow.
  always_comb begin
    io_in     = '0;
    fifo_pop  = '0;
    fill_edge = '0;
    rd_ok     = 1'b0;
    for (int k = 0; k < NUIOIN; k++) begin
      fill_edge[k] = fifo_push[k] & (fifo_count[k] == '0);
      if (addr_in == AIW'(k) && !fifo_empty[k]) begin
        io_in       = fifo_rdata[k];
        fifo_pop[k] = req_in;
        rd_ok       = 1'b1;
      end
    end
    err_udf_d = err_udf_q | (req_in & ~rd_ok);
    itr_d     = |(fill_edge & ITRMSK);
  end

  // Write side: a new write always wins over a same-cycle consumer handshake.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_hit      = 1'b0;
    ovr_set     = 1'b0;
    for (int j = 0; j < NUIOOU; j++) begin
      if (out_en && addr_out == AOW'(j)) begin
        wr_hit         = 1'b1;
        ovr_set        = out_valid_q[j] & ~out_ready[j];
        out_data_d[j]  = io_out;
        out_valid_d[j] = 1'b1;
      end else if (out_valid_q[j] && out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
    if (out_en && !wr_hit) ovr_set = 1'b1;
    err_ovr_d = err_ovr_q | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUIOOU; j++) out_data_q[j] <= '0;
      out_valid_q <= '0;
      itr_q       <= 1'b0;
      err_udf_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      itr_q       <= itr_d;
      err_udf_q   <= err_udf_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign itr       = itr_q;
  assign err_udf   = err_udf_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Self-checking bench for io_port_hub: directed scenarios then random traffic against a queue model.
module tb_io_port_hub;

  localparam int NUBITS = 16;
  localparam int NUIOIN = 2;
  localparam int NUIOOU = 2;
  localparam int FDEPTH = 4;
  localparam logic [NUIOIN-1:0] ITRMSK = '1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUBITS-1:0]           io_in;
  logic [$clog2(NUIOIN)-1:0]   addr_in;
  logic                        req_in;
  logic [NUBITS-1:0]           io_out;
  logic [$clog2(NUIOOU)-1:0]   addr_out;
  logic                        out_en;
  logic                        itr;
  logic [NUIOIN*NUBITS-1:0]    in_data;
  logic [NUIOIN-1:0]           in_valid;
  logic [NUIOIN-1:0]           in_ready;
  logic [NUIOOU*NUBITS-1:0]    out_data;
  logic [NUIOOU-1:0]           out_valid;
  logic [NUIOOU-1:0]           out_ready;
  logic                        err_udf;
  logic                        err_ovr;

  io_port_hub #(
    .NUBITS (NUBITS),
    .NUIOIN (NUIOIN),
    .NUIOOU (NUIOOU),
    .FDEPTH (FDEPTH),
    .ITRMSK (ITRMSK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io_in     (io_in),
    .addr_in   (addr_in),
    .req_in    (req_in),
    .io_out    (io_out),
    .addr_out  (addr_out),
    .out_en    (out_en),
    .itr       (itr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_udf   (err_udf),
    .err_ovr   (err_ovr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NUBITS-1:0] fq [NUIOIN][$];
  logic [NUBITS-1:0] od_m [NUIOOU];
  logic [NUIOOU-1:0] ov_m;
  logic              udf_m, ovr_m, itr_m;

  int n_cmp = 0;
  int n_err = 0;

  logic              mon_en = 1'b0;
  logic [NUBITS-1:0] seen [$];
  logic [NUBITS-1:0] sent [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int   sz_b [NUIOIN];
    logic nitr;
    if (!rst) begin
      for (int k = 0; k < NUIOIN; k++) fq[k].delete();
      for (int j = 0; j < NUIOOU; j++) od_m[j] = '0;
      ov_m  = '0;
      udf_m = 1'b0;
      ovr_m = 1'b0;
      itr_m = 1'b0;
      return;
    end
    for (int k = 0; k < NUIOIN; k++) sz_b[k] = fq[k].size();
    if (req_in) begin
      if (int'(addr_in) < NUIOIN && sz_b[addr_in] > 0) void'(fq[addr_in].pop_front());
      else udf_m = 1'b1;
    end
    nitr = 1'b0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (in_valid[k] && sz_b[k] < FDEPTH) begin
        fq[k].push_back(in_data[k*NUBITS +: NUBITS]);
        if (sz_b[k] == 0 && ITRMSK[k]) nitr = 1'b1;
      end
    end
    itr_m = nitr;
    if (out_en) begin
      if (int'(addr_out) >= NUIOOU) ovr_m = 1'b1;
      else begin
        if (ov_m[addr_out] && !out_ready[addr_out]) ovr_m = 1'b1;
        od_m[addr_out] = io_out;
      end
    end
    for (int j = 0; j < NUIOOU; j++) begin
      if (out_en && int'(addr_out) == j) ov_m[j] = 1'b1;
      else if (ov_m[j] && out_ready[j]) ov_m[j] = 1'b0;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs after the edge.
  task automatic tick();
    logic [NUBITS-1:0]        exp_io;
    logic [NUIOIN-1:0]        exp_rdy;
    logic [NUIOOU*NUBITS-1:0] exp_od;
    @(negedge clk);
    exp_io = '0;
    if (int'(addr_in) < NUIOIN && fq[addr_in].size() != 0) exp_io = fq[addr_in][0];
    for (int k = 0; k < NUIOIN; k++) exp_rdy[k] = rst && (fq[k].size() < FDEPTH);
    check("io_in", io_in, exp_io);
    check("in_ready", in_ready, exp_rdy);
    if (mon_en && out_valid[0] && out_ready[0]) seen.push_back(out_data[NUBITS-1:0]);
    model_step();
    @(posedge clk);
    #1;
    for (int j = 0; j < NUIOOU; j++) exp_od[j*NUBITS +: NUBITS] = od_m[j];
    check("itr", itr, itr_m);
    check("out_valid", out_valid, ov_m);
    check("out_data", out_data, exp_od);
    check("err_udf", err_udf, udf_m);
    check("err_ovr", err_ovr, ovr_m);
  endtask

  task automatic idle();
    rst = 1'b1; req_in = 1'b0; addr_in = '0; out_en = 1'b0; addr_out = '0;
    io_out = '0; in_valid = '0; in_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    out_ready = '0;
    for (int k = 0; k < NUIOIN; k++) fq[k].delete();

    // Reset with producers trying to push: nothing accepted, in_ready low
    rst = 1'b0; in_valid = '1; in_data = {16'hdead, 16'hbeef};
    tick(); tick();
    check("rst_in_ready", in_ready, 2'b00);
    idle();
    tick();
    check("release_in_ready", in_ready, 2'b11);
    check("release_itr", itr, 1'b0);

    // Two words on ch0, read back in order, single itr pulse
    in_valid = 2'b01; in_data[15:0] = 16'h0011;
    tick();
    check("push1_itr", itr, 1'b1);
    in_data[15:0] = 16'h0022;
    tick();
    check("push2_itr", itr, 1'b0);
    idle(); req_in = 1'b1; addr_in = 1'b0;
    #1 check("rd_first", io_in, 16'h0011);
    tick();
    #1 check("rd_second", io_in, 16'h0022);
    tick();
    check("no_udf_yet", err_udf, 1'b0);

    // Fill ch1, then push+pop at full, then push+pop at three words
    idle(); in_valid = 2'b10;
    for (int i = 1; i <= FDEPTH; i++) begin
      in_data[31:16] = 16'h0100 + 16'(i);
      tick();
    end
    check("full_ready", in_ready[1], 1'b0);
    in_data[31:16] = 16'h0105; req_in = 1'b1; addr_in = 1'b1;
    #1 check("full_head", io_in, 16'h0101);
    tick();
    in_data[31:16] = 16'h0106;
    #1 check("pp_head", io_in, 16'h0102);
    tick();
    in_valid = '0;
    repeat (4) tick();

    // Underflow on empty ch0, sticky afterwards
    idle(); req_in = 1'b1; addr_in = 1'b0;
    #1 check("udf_io_in", io_in, 16'h0000);
    tick();
    check("udf_set", err_udf, 1'b1);
    idle();
    repeat (2) tick();
    check("udf_sticky", err_udf, 1'b1);

    // Overrun on output ch1
    out_ready = '0; out_en = 1'b1; addr_out = 1'b1; io_out = 16'h1234;
    tick();
    io_out = 16'h5678;
    tick();
    check("ovr_set", err_ovr, 1'b1);
    check("ovr_data", out_data[31:16], 16'h5678);
    idle(); out_ready = 2'b10;
    tick();

    // Back-to-back writes to ch0 with consumer ready: valid held, each word seen once
    out_ready = 2'b01; mon_en = 1'b1; out_en = 1'b1; addr_out = 1'b0;
    for (int i = 0; i < 6; i++) begin
      io_out = 16'h0a00 + 16'(i);
      sent.push_back(io_out);
      tick();
      check("stream_valid", out_valid[0], 1'b1);
    end
    out_en = 1'b0;
    tick();
    mon_en = 1'b0;
    check("stream_count", seen.size(), sent.size());
    for (int i = 0; i < sent.size() && i < seen.size(); i++) check("stream_word", seen[i], sent[i]);

    // Reset with buffered words and a valid output
    idle(); out_ready = '0; in_valid = 2'b11; in_data = {16'h0b0b, 16'h0a0a};
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h7777;
    tick();
    idle(); rst = 1'b0;
    tick();
    check("rst_valid", out_valid, 2'b00);
    check("rst_itr", itr, 1'b0);
    check("rst_errs", {err_udf, err_ovr}, 2'b00);
    idle();
    tick();
    check("post_rst_itr", itr, 1'b0);
    check("post_rst_io_in", io_in, 16'h0000);
    in_valid = 2'b01; in_data[15:0] = 16'h0c0c;
    tick();
    check("post_rst_push_itr", itr, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) != 0);
      req_in    = $urandom_range(0, 1) == 1;
      addr_in   = $urandom_range(0, NUIOIN - 1);
      in_valid  = $urandom_range(0, 3);
      in_data   = {$urandom, $urandom};
      out_en    = $urandom_range(0, 1) == 1;
      addr_out  = $urandom_range(0, NUIOOU - 1);
      io_out    = NUBITS'($urandom);
      out_ready = $urandom_range(0, 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
